// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier evaluation blocks.
// Holds the default operand width, accumulator sizing and evaluator state encoding.
package approx_mult_pkg;

    localparam int unsigned DEFAULT_W = 4;

    // SED accumulator must hold 2^(2W) * (2^W - 1)^2 without wrapping.
    function automatic int unsigned acc_width(input int unsigned w);
        return 4 * w;
    endfunction

    function automatic int unsigned num_pairs(input int unsigned w);
        return 1 << (2 * w);
    endfunction

    localparam int unsigned NUM_PAIRS = 1 << (2 * DEFAULT_W);

    typedef logic [1:0] eval_state_t;

    localparam eval_state_t ST_IDLE  = 2'd0;
    localparam eval_state_t ST_SWEEP = 2'd1;
    localparam eval_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/exact_mult_ref.sv
// Exact W x W unsigned combinational multiplier used as the golden product
// when grading approximate multipliers.
module exact_mult_ref #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/approx_mult_error_evaluator.sv
// Sweeps every operand pair through a combinational multiplier under test and
// accumulates error count, sum of error distance and worst-case error with its operands.
module approx_mult_error_evaluator
    import approx_mult_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned ACC_W = acc_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   y_approx,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b
);

    if (ACC_W < 4 * W) begin : gen_bad_acc_w
        $error("ACC_W must be at least 4*W");
    end

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_sync_q1, rst_sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q1 <= 1'b0;
            rst_sync_q2 <= 1'b0;
        end else begin
            rst_sync_q1 <= 1'b1;
            rst_sync_q2 <= rst_sync_q1;
        end
    end

    eval_state_t      state_q, state_d;
    logic [2*W-1:0]   idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*W:0]     err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [2*W-1:0]   max_q, max_d;
    logic [W-1:0]     max_a_q, max_a_d;
    logic [W-1:0]     max_b_q, max_b_d;

    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   ed;

    // Operands come straight from the index register; idx wraps to 0 as the sweep ends.
    assign op_a = idx_q[2*W-1:W];
    assign op_b = idx_q[W-1:0];

    exact_mult_ref #(
        .W (W)
    ) u_exact (
        .a (op_a),
        .b (op_b),
        .p (exact)
    );

    assign ed = (y_approx >= exact) ? (y_approx - exact) : (exact - y_approx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;
        max_a_d = max_a_q;
        max_b_d = max_b_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    max_a_d = '0;
                    max_b_d = '0;
                end
            end
            ST_SWEEP: begin
                if (ed != '0) begin
                    err_d = err_q + (2*W+1)'(1);
                    sum_d = sum_q + ACC_W'(ed);
                end
                // Strict compare keeps the earliest pair on ties.
                if (ed > max_q) begin
                    max_d   = ed;
                    max_a_d = op_a;
                    max_b_d = op_b;
                end
                idx_d = idx_q + (2*W)'(1);
                if (&idx_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q2) begin
        if (!rst_sync_q2) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            max_a_q <= '0;
            max_b_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            max_a_q <= max_a_d;
            max_b_q <= max_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign max_a     = max_a_q;
    assign max_b     = max_b_q;

endmodule

// File: tb/tb_approx_mult_error_evaluator.sv
// Bench for approx_mult_error_evaluator: several multiplier-under-test behaviours,
// metrics graded against an exhaustive arithmetic model of the error statistics.
module tb_approx_mult_error_evaluator;

    localparam int W     = 4;
    localparam int ACC_W = 16;
    localparam int PAIRS = 256;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [2*W-1:0]   y_approx;
    logic             busy;
    logic             done;
    logic [2*W:0]     err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [2*W-1:0]   max_ed;
    logic [W-1:0]     max_a;
    logic [W-1:0]     max_b;

    int n_checks = 0;
    int n_errors = 0;
    int mode;
    logic [2*W-1:0] y_tab [PAIRS];

    approx_mult_error_evaluator #(
        .W     (W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .y_approx  (y_approx),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .max_a     (max_a),
        .max_b     (max_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier-under-test behaviours: 0 exact, 1 lsb flipped, 2 stuck at zero,
    // 3 single +7 fault at (3,5), 4 random table.
    function automatic int mut_y(input int m, input int a, input int b);
        int p;
        p = a * b;
        case (m)
            0:       return p;
            1:       return p ^ 1;
            2:       return 0;
            3:       return (a == 3 && b == 5) ? p + 7 : p;
            default: return int'(y_tab[a * 16 + b]);
        endcase
    endfunction

    always_comb begin
        y_approx = '0;
        if (mode == 4) y_approx = y_tab[{op_a, op_b}];
        else           y_approx = 8'(mut_y(mode, int'(op_a), int'(op_b)));
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_sweep(input int m, output int e_cnt, output int e_sum,
                               output int e_max, output int e_a, output int e_b);
        e_cnt = 0; e_sum = 0; e_max = 0; e_a = 0; e_b = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int y, d;
                y = mut_y(m, a, b);
                d = (y > a * b) ? y - a * b : a * b - y;
                if (d != 0) begin
                    e_cnt++;
                    e_sum += d;
                end
                if (d > e_max) begin
                    e_max = d; e_a = a; e_b = b;
                end
            end
        end
    endtask

    task automatic run_sweep(input int restart_at, output int done_edge,
                             output int busy_cycles, output int done_pulses);
        done_edge = -1; busy_cycles = 0; done_pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == restart_at) start = 1'b1;
            else if (n == restart_at + 1) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_edge < 0) done_edge = n;
            end
            if (done_edge > 0 && n > done_edge + 1) break;
        end
    endtask

    task automatic sweep_and_check(input string name, input int m, input int restart_at);
        int de, bc, dp, e_cnt, e_sum, e_max, e_a, e_b;
        mode = m;
        model_sweep(m, e_cnt, e_sum, e_max, e_a, e_b);
        run_sweep(restart_at, de, bc, dp);
        check_val({name, ".done_edge"}, 64'(de), 64'(257));
        check_val({name, ".busy_cycles"}, 64'(bc), 64'(256));
        check_val({name, ".done_pulses"}, 64'(dp), 64'(1));
        check_val({name, ".err_count"}, 64'(err_count), 64'(e_cnt));
        check_val({name, ".sum_ed"}, 64'(sum_ed), 64'(e_sum));
        check_val({name, ".max_ed"}, 64'(max_ed), 64'(e_max));
        check_val({name, ".max_a"}, 64'(max_a), 64'(e_a));
        check_val({name, ".max_b"}, 64'(max_b), 64'(e_b));
        check_val({name, ".op_idle"}, 64'({op_a, op_b}), 64'(0));
        check_val({name, ".busy_end"}, 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, ".op_a"}, 64'(op_a), 64'(0));
        check_val({name, ".op_b"}, 64'(op_b), 64'(0));
        check_val({name, ".busy"}, 64'(busy), 64'(0));
        check_val({name, ".done"}, 64'(done), 64'(0));
        check_val({name, ".err_count"}, 64'(err_count), 64'(0));
        check_val({name, ".sum_ed"}, 64'(sum_ed), 64'(0));
        check_val({name, ".max_ed"}, 64'(max_ed), 64'(0));
        check_val({name, ".max_a"}, 64'(max_a), 64'(0));
        check_val({name, ".max_b"}, 64'(max_b), 64'(0));
    endtask

    initial begin
        int reached, seen_done, e_cnt, e_sum, e_max, e_a, e_b;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < PAIRS; i++) begin
            if ($urandom_range(0, 3) == 0) y_tab[i] = 8'($urandom_range(0, 255));
            else                           y_tab[i] = 8'((i / 16) * (i % 16));
        end

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        sweep_and_check("exact", 0, -1);
        sweep_and_check("lsb_flip", 1, -1);
        sweep_and_check("zero", 2, -1);
        sweep_and_check("single_fault", 3, -1);
        sweep_and_check("random", 4, -1);

        // Metrics must persist in DONE until the next start.
        model_sweep(4, e_cnt, e_sum, e_max, e_a, e_b);
        repeat (5) @(negedge clk);
        check_val("hold.err_count", 64'(err_count), 64'(e_cnt));
        check_val("hold.sum_ed", 64'(sum_ed), 64'(e_sum));

        sweep_and_check("start_mid_sweep", 4, 50);
        sweep_and_check("restart_from_done", 4, -1);

        // Reset in the middle of a sweep.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ({op_a, op_b} == 8'd100) begin
                reached = 1;
                break;
            end
        end
        check_val("midreset.reached_idx", 64'(reached), 64'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        seen_done = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check_val("midreset.no_done", 64'(seen_done), 64'(0));
        check_val("midreset.busy_after", 64'(busy), 64'(0));
        sweep_and_check("after_reset", 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_mult_error_evaluator.md
Name: approx_mult_error_evaluator

Overview:
Sequential, self-sweeping accuracy evaluator for the approximate recursive multipliers. It drives every operand pair (a, b) of a W×W multiplier under test (MUT) and samples the MUT's approximate product. It compares that product against an internal exact product and accumulates error metrics: error count, sum of error distance (SED) and maximum error distance with its operands. It is the consumer end of the multiplier's a/b/Y interface and is used in hardware self-characterisation of M-series blocks.

Parameters:
W, 4, operand width of the MUT (product width 2W)
ACC_W, 4*W, SED accumulator width (holds 2^(2W)·(2^W−1)^2 without overflow)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE or DONE
op_a  output  W  operand a driven to MUT (registered)
op_b  output  W  operand b driven to MUT (registered)
y_approx  input  2W  MUT product; the MUT is combinational and settles within the same cycle
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when the sweep completes
err_count  output  2W+1  number of pairs with y_approx ≠ exact
sum_ed  output  ACC_W  Σ|y_approx − exact|
max_ed  output  2W  largest |y_approx − exact|
max_a  output  W  op_a at the first occurrence of max_ed
max_b  output  W  op_b at the first occurrence of max_ed

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE; all outputs 0: op_a, op_b, busy, done, err_count, sum_ed, max_ed, max_a, max_b.
  - Reset mid-sweep abandons the sweep; no done pulse.
- States: IDLE, SWEEP, DONE.
- IDLE/DONE + start=1:
  - Clear all metrics and the 2W-bit index idx to 0.
  - busy=1 next cycle; go to SWEEP.
  - Metrics hold their last values until start clears them.
- SWEEP:
  - op_a = idx[2W-1:W], op_b = idx[W-1:0], both registered from idx.
  - Each cycle, compute exact = op_a·op_b (combinational) and ed = |y_approx − exact| (2W bits, unsigned magnitude).
  - If ed≠0: err_count += 1 and sum_ed += ed.
  - If ed > max_ed (strict): load max_ed, max_a, max_b. Ties keep the earlier pair.
  - idx increments every cycle.
  - On the cycle evaluating idx = 2^(2W)−1, go to DONE next edge with done=1 for that one cycle and busy=0.
  - op_a/op_b return to 0 on entry to DONE.
- Latency: start sampled at edge 0; the first pair is evaluated in cycle 1. For W=4, done is asserted at edge 257 (256 evaluation cycles + 1).
- start while in SWEEP is ignored; no restart.
- start while in DONE restarts immediately and done is not re-pulsed.
- No saturation logic is needed; ACC_W covers the worst case. Any ACC_W override below 4W is illegal.
- err_count reaches at most 2^(2W) and needs 2W+1 bits.

Decomposition:
- Shared package approx_mult_pkg:
  - default W
  - function acc_width(W) = 4W
  - state enum {IDLE, SWEEP, DONE}
  - constant NUM_PAIRS = 2^(2W)
- One sub-module, exact_mult_ref (W×W unsigned exact multiplier, combinational, 2W output). It serves as the golden reference and is reusable by the other evaluator benches.
- abs-diff and accumulators stay in the top module.

Test Plan:
- Bench MUT = exact model (y_approx = op_a·op_b), start pulsed once. Expect done at edge 257, busy high for 256 cycles, and err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0.
- y_approx = exact XOR 1. Expect err_count=256, sum_ed=256, max_ed=1, max_a=0, max_b=0 (first pair, tie rule).
- y_approx tied to 0. Expect err_count=225, sum_ed=14400 (=120²), max_ed=225, max_a=15, max_b=15.
- y_approx = exact+7 only when a=3 and b=5. Expect err_count=1, sum_ed=7, max_ed=7, max_a=3, max_b=5.
- Assert rst_n low while idx=100. Expect all outputs 0 asynchronously, state IDLE, no done pulse. A subsequent start gives a full clean 256-cycle sweep.
- Pulse start at cycle 50 of a sweep, then again after done. Expect the first to have no effect (done still at edge 257). Expect the second to clear metrics and complete a fresh sweep with identical results.
